regfile_wr_ctrl: RTL

Write-side controller that sits directly upstream of the 16 x 32-bit register bank and drives its per-register load strobes and shared write data. It accepts a write command (start address, burst length) and then a stream of data beats over valid/ready handshakes. Each beat becomes one registered one-hot load strobe plus data word. The address auto-increments with wrap-around.

---
 rtl/regfile_wr_pkg.sv | 13 +
 rtl/regfile_wr_ctrl_if.sv | 31 +++
 rtl/regfile_wr_dec.sv | 10 +
 rtl/regfile_wr_ctrl.sv | 84 ++++++++
 4 files changed

// File: rtl/regfile_wr_pkg.sv
// regfile_wr_pkg: shared sizes, FSM state type and parity helper for the register bank write controller
package regfile_wr_pkg;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic {IDLE, DATA} wr_state_t;

    // Even parity: the parity bit equals the XOR of all data bits
    function automatic logic par_ok(input logic [DATA_W-1:0] data, input logic par);
        return (^data) == par;
    endfunction
endpackage

// File: rtl/regfile_wr_ctrl_if.sv
// regfile_wr_ctrl_if: command and write-data channels of the register bank write controller
// wdata_par exists only when REGFILE_WR_PARITY_EN is defined
interface regfile_wr_ctrl_if;
    import regfile_wr_pkg::*;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;
`ifdef REGFILE_WR_PARITY_EN
    logic              wdata_par;
`endif

    modport master (
        output cmd_valid, cmd_addr, cmd_len, wdata_valid, wdata,
`ifdef REGFILE_WR_PARITY_EN
        output wdata_par,
`endif
        input  cmd_ready, wdata_ready
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, wdata_valid, wdata,
`ifdef REGFILE_WR_PARITY_EN
        input  wdata_par,
`endif
        output cmd_ready, wdata_ready
    );
endinterface

// File: rtl/regfile_wr_dec.sv
// regfile_wr_dec: combinational register index to one-hot strobe decoder with enable
module regfile_wr_dec
    import regfile_wr_pkg::*;
(
    input  logic                en,
    input  logic [ADDR_W-1:0]   addr,
    output logic [NUM_REGS-1:0] onehot
);
    assign onehot = en ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << addr) : '0;
endmodule

// File: rtl/regfile_wr_ctrl.sv
// regfile_wr_ctrl: turns a write command plus a beat stream into registered one-hot loads with wrapping address
// Optional REGFILE_WR_PARITY_EN drops beats with bad even parity and flags a sticky err
module regfile_wr_ctrl
    import regfile_wr_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    regfile_wr_ctrl_if.slave    bus,
`ifdef REGFILE_WR_PARITY_EN
    input  logic                err_clr,
    output logic                err,
`endif
    output logic [NUM_REGS-1:0] load,
    output logic [DATA_W-1:0]   data_out,
    output logic                busy,
    output logic                done
);
    wr_state_t             state, state_nxt;
    logic [ADDR_W-1:0]     cur_addr, remaining;
    logic                  cmd_fire, beat, last, ok, write;
    logic [NUM_REGS-1:0]   onehot;

    assign cmd_fire = (state == IDLE) && bus.cmd_valid;
    assign beat     = (state == DATA) && bus.wdata_valid;
    assign last     = remaining == '0;
`ifdef REGFILE_WR_PARITY_EN
    assign ok       = par_ok(bus.wdata, bus.wdata_par);
`else
    assign ok       = 1'b1;
`endif
    assign write    = beat && ok;

    // Ready/busy come straight from the state register, never from a valid
    assign bus.cmd_ready   = state == IDLE;
    assign bus.wdata_ready = state == DATA;
    assign busy            = state == DATA;

    regfile_wr_dec u_dec (
        .en     (write),
        .addr   (cur_addr),
        .onehot (onehot)
    );

    always_comb begin
        state_nxt = state;
        state_nxt = cmd_fire ? DATA : (beat && last) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            load      <= '0;
            data_out  <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            load  <= onehot;
            done  <= beat && last;
            if (write)
                data_out <= bus.wdata;
            if (cmd_fire) begin
                cur_addr  <= bus.cmd_addr;
                remaining <= bus.cmd_len;
            end else if (beat) begin
                cur_addr  <= cur_addr + ADDR_W'(1);
                remaining <= last ? remaining : remaining - ADDR_W'(1);
            end
        end
    end

`ifdef REGFILE_WR_PARITY_EN
    // A coinciding mismatch beats a clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err <= 1'b0;
        else if (beat && !ok)
            err <= 1'b1;
        else if (err_clr)
            err <= 1'b0;
    end
`endif
endmodule
